// File: rtl/axi4_protocol_monitor_if.sv
// AXI4 channel bundle (handshakes plus the payload fields the protocol monitor observes).
// Masters and slaves use the matching modports; the monitor modport only listens.
interface axi4_protocol_monitor_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    AWVALID;
    logic                    AWREADY;
    logic [ID_WIDTH-1:0]     AWID;
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [7:0]              AWLEN;
    logic [2:0]              AWSIZE;
    logic [1:0]              AWBURST;
    logic                    WVALID;
    logic                    WREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WLAST;
    logic                    BVALID;
    logic                    BREADY;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [ID_WIDTH-1:0]     ARID;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [7:0]              ARLEN;
    logic [2:0]              ARSIZE;
    logic [1:0]              ARBURST;
    logic                    RVALID;
    logic                    RREADY;
    logic                    RLAST;

    modport master (
        output AWVALID, AWID, AWADDR, AWLEN, AWSIZE, AWBURST,
        output WVALID, WDATA, WSTRB, WLAST, BREADY,
        output ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, RREADY,
        input  AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST
    );

    modport slave (
        input  AWVALID, AWID, AWADDR, AWLEN, AWSIZE, AWBURST,
        input  WVALID, WDATA, WSTRB, WLAST, BREADY,
        input  ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, RREADY,
        output AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST
    );

    modport monitor (
        input AWVALID, AWREADY, AWID, AWADDR, AWLEN, AWSIZE, AWBURST,
        input WVALID, WREADY, WDATA, WSTRB, WLAST, BVALID, BREADY,
        input ARVALID, ARREADY, ARID, ARADDR, ARLEN, ARSIZE, ARBURST,
        input RVALID, RREADY, RLAST
    );
endinterface

// File: rtl/axi4_protocol_monitor.sv
// Passive AXI4 protocol checker: tracks outstanding bursts per direction and reports
// rule violations as a registered one-cycle pulse plus a sticky status vector.
module axi4_protocol_monitor #(
    parameter int ID_WIDTH        = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 8,
    parameter int MAX_BURST_LEN   = 16,
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      clear_status,
    axi4_protocol_monitor_if.monitor  bus,
    output logic                      err_valid,
    output logic [3:0]                err_code,
    output logic [12:0]               err_status,
    output logic [CW-1:0]             wr_outstanding,
    output logic [CW-1:0]             rd_outstanding
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam logic [CW-1:0] FULL = CW'(MAX_OUTSTANDING);

    logic [7:0]              awFifo [MAX_OUTSTANDING];
    logic [7:0]              arFifo [MAX_OUTSTANDING];
    logic [PW-1:0]           awWrPtr, awRdPtr, arWrPtr, arRdPtr;
    logic [CW-1:0]           awCount, wrDone;
    logic [7:0]              wBeat, rBeat;
    logic                    armed;
    logic                    prevAwWait, prevWWait, prevArWait;
    logic [ID_WIDTH-1:0]     prevAwId, prevArId;
    logic [ADDR_WIDTH-1:0]   prevAwAddr, prevArAddr;
    logic [7:0]              prevAwLen, prevArLen;
    logic [2:0]              prevAwSize, prevArSize;
    logic [1:0]              prevAwBurst, prevArBurst;
    logic [DATA_WIDTH-1:0]   prevWData;
    logic [DATA_WIDTH/8-1:0] prevWStrb;
    logic                    prevWLast;

    logic        awHs, wHs, bHs, arHs, rHs, awPush, arPush;
    logic        wHasBurst, rHasBurst, wPop, rPop;
    logic [7:0]  wHeadLen, rHeadLen;
    logic [20:0] awEnd, arEnd;
    logic [12:0] viol, v;
    logic [3:0]  lowIdx;

    // Same-cycle address handshakes feed the data channel directly when the FIFO is empty.
    always_comb begin
        awHs      = bus.AWVALID && bus.AWREADY;
        wHs       = bus.WVALID && bus.WREADY;
        bHs       = bus.BVALID && bus.BREADY;
        arHs      = bus.ARVALID && bus.ARREADY;
        rHs       = bus.RVALID && bus.RREADY;
        awPush    = awHs && (wr_outstanding != FULL);
        arPush    = arHs && (rd_outstanding != FULL);
        wHeadLen  = (awCount == '0) ? bus.AWLEN : awFifo[awRdPtr];
        rHeadLen  = (rd_outstanding == '0) ? bus.ARLEN : arFifo[arRdPtr];
        wHasBurst = (awCount != '0) || awPush;
        rHasBurst = (rd_outstanding != '0) || arPush;
        wPop      = wHs && wHasBurst && (wBeat == wHeadLen);
        rPop      = rHs && rHasBurst && (bus.RLAST || (rBeat == rHeadLen));
        awEnd     = 21'(bus.AWADDR[11:0]) + ((21'(bus.AWLEN) + 21'd1) << bus.AWSIZE);
        arEnd     = 21'(bus.ARADDR[11:0]) + ((21'(bus.ARLEN) + 21'd1) << bus.ARSIZE);

        viol     = '0;
        viol[0]  = prevAwWait && (!bus.AWVALID || bus.AWID != prevAwId || bus.AWADDR != prevAwAddr
                   || bus.AWLEN != prevAwLen || bus.AWSIZE != prevAwSize || bus.AWBURST != prevAwBurst);
        viol[1]  = prevWWait && (!bus.WVALID || bus.WDATA != prevWData || bus.WSTRB != prevWStrb
                   || bus.WLAST != prevWLast);
        viol[2]  = prevArWait && (!bus.ARVALID || bus.ARID != prevArId || bus.ARADDR != prevArAddr
                   || bus.ARLEN != prevArLen || bus.ARSIZE != prevArSize || bus.ARBURST != prevArBurst);
        viol[3]  = bus.AWVALID && (({1'b0, bus.AWLEN} + 9'd1) > 9'(MAX_BURST_LEN));
        viol[4]  = bus.ARVALID && (({1'b0, bus.ARLEN} + 9'd1) > 9'(MAX_BURST_LEN));
        viol[5]  = wHs && wHasBurst && bus.WLAST && (wBeat < wHeadLen);
        viol[6]  = wHs && wHasBurst && !bus.WLAST && (wBeat == wHeadLen);
        viol[7]  = wHs && (awCount == '0) && !awHs;
        viol[8]  = bHs && (wrDone == '0);
        viol[9]  = rHs && (rd_outstanding == '0) && !arHs;
        viol[10] = rHs && rHasBurst && (bus.RLAST != (rBeat == rHeadLen));
        viol[11] = (awHs && (wr_outstanding == FULL)) || (arHs && (rd_outstanding == FULL));
        viol[12] = (bus.AWVALID && bus.AWBURST == 2'b01 && awEnd > 21'd4096)
                || (bus.ARVALID && bus.ARBURST == 2'b01 && arEnd > 21'd4096);
        v        = armed ? viol : '0;

        lowIdx = 4'd0;
        for (int i = 12; i >= 0; i--) begin
            if (v[i]) lowIdx = 4'(i);
        end
    end

    // wr_outstanding only drops on a B that matches a completed burst, so it always
    // equals queued bursts plus bursts awaiting their response.
    always_ff @(posedge clock) begin
        if (reset) begin
            awWrPtr <= '0; awRdPtr <= '0; arWrPtr <= '0; arRdPtr <= '0;
            awCount <= '0; wrDone <= '0; wBeat <= '0; rBeat <= '0;
            armed <= 1'b0;
            prevAwWait <= 1'b0; prevWWait <= 1'b0; prevArWait <= 1'b0;
            prevAwId <= '0; prevAwAddr <= '0; prevAwLen <= '0; prevAwSize <= '0; prevAwBurst <= '0;
            prevArId <= '0; prevArAddr <= '0; prevArLen <= '0; prevArSize <= '0; prevArBurst <= '0;
            prevWData <= '0; prevWStrb <= '0; prevWLast <= 1'b0;
            err_valid <= 1'b0; err_code <= '0; err_status <= '0;
            wr_outstanding <= '0; rd_outstanding <= '0;
        end else begin
            armed      <= 1'b1;
            prevAwWait <= bus.AWVALID && !bus.AWREADY;
            prevWWait  <= bus.WVALID && !bus.WREADY;
            prevArWait <= bus.ARVALID && !bus.ARREADY;
            prevAwId   <= bus.AWID;   prevAwAddr <= bus.AWADDR; prevAwLen <= bus.AWLEN;
            prevAwSize <= bus.AWSIZE; prevAwBurst <= bus.AWBURST;
            prevArId   <= bus.ARID;   prevArAddr <= bus.ARADDR; prevArLen <= bus.ARLEN;
            prevArSize <= bus.ARSIZE; prevArBurst <= bus.ARBURST;
            prevWData  <= bus.WDATA;  prevWStrb <= bus.WSTRB;   prevWLast <= bus.WLAST;

            if (awPush) begin
                awFifo[awWrPtr] <= bus.AWLEN;
                awWrPtr <= awWrPtr + PW'(1);
            end
            if (wPop) awRdPtr <= awRdPtr + PW'(1);
            awCount <= awCount + CW'(awPush) - CW'(wPop);
            if (wHs && wHasBurst) wBeat <= wPop ? 8'd0 : wBeat + 8'd1;
            wrDone <= wrDone + CW'(wPop) - CW'(bHs && (wrDone != '0));
            wr_outstanding <= wr_outstanding + CW'(awPush) - CW'(bHs && (wrDone != '0));

            if (arPush) begin
                arFifo[arWrPtr] <= bus.ARLEN;
                arWrPtr <= arWrPtr + PW'(1);
            end
            if (rPop) arRdPtr <= arRdPtr + PW'(1);
            if (rHs && rHasBurst) rBeat <= rPop ? 8'd0 : rBeat + 8'd1;
            rd_outstanding <= rd_outstanding + CW'(arPush) - CW'(rPop);

            err_valid <= enable && (|v);
            err_code  <= lowIdx;
            if (clear_status)
                err_status <= '0;
            else if (enable)
                err_status <= err_status | v;
        end
    end
endmodule

// File: tb/tb_axi4_protocol_monitor.sv
// Scoreboard bench for axi4_protocol_monitor: directed protocol scenarios then random
// traffic, each cycle's expected outputs coming from a queue-based reference model.
module tb_axi4_protocol_monitor;
    localparam int MAXO = 8;
    localparam int MAXB = 16;
    localparam int CW   = 4;

    logic          clock = 1'b0;
    logic          reset, enable, clear_status;
    logic          err_valid;
    logic [3:0]    err_code;
    logic [12:0]   err_status;
    logic [CW-1:0] wr_outstanding, rd_outstanding;

    axi4_protocol_monitor_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi4_protocol_monitor #(
        .ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .MAX_OUTSTANDING(MAXO), .MAX_BURST_LEN(MAXB)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .clear_status(clear_status),
        .bus(bus),
        .err_valid(err_valid), .err_code(err_code), .err_status(err_status),
        .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic rst, en, clr;
        logic awv, awr; logic [3:0] awid; logic [31:0] awaddr; logic [7:0] awlen;
        logic [2:0] awsize; logic [1:0] awburst;
        logic wv, wr; logic [31:0] wdata; logic [3:0] wstrb; logic wlast;
        logic bv, br;
        logic arv, arr; logic [3:0] arid; logic [31:0] araddr; logic [7:0] arlen;
        logic [2:0] arsize; logic [1:0] arburst;
        logic rv, rr, rlast;
    } stim_t;

    typedef struct packed {
        logic ev; logic [3:0] ec; logic [12:0] es; logic [3:0] wo; logic [3:0] ro;
    } exp_t;

    stim_t       st, prevSt;
    exp_t        expQ[$];
    int          awQ[$];
    int          arQ[$];
    int          wBeatM, rBeatM, doneM;
    bit          armedM;
    logic [12:0] statusM;
    int          checks = 0;
    int          failures = 0;

    task automatic driveBus();
        reset = st.rst; enable = st.en; clear_status = st.clr;
        bus.AWVALID = st.awv; bus.AWREADY = st.awr; bus.AWID = st.awid; bus.AWADDR = st.awaddr;
        bus.AWLEN = st.awlen; bus.AWSIZE = st.awsize; bus.AWBURST = st.awburst;
        bus.WVALID = st.wv; bus.WREADY = st.wr; bus.WDATA = st.wdata; bus.WSTRB = st.wstrb;
        bus.WLAST = st.wlast; bus.BVALID = st.bv; bus.BREADY = st.br;
        bus.ARVALID = st.arv; bus.ARREADY = st.arr; bus.ARID = st.arid; bus.ARADDR = st.araddr;
        bus.ARLEN = st.arlen; bus.ARSIZE = st.arsize; bus.ARBURST = st.arburst;
        bus.RVALID = st.rv; bus.RREADY = st.rr; bus.RLAST = st.rlast;
    endtask

    // Reference model: bursts are queue entries, beats and completions are plain counters.
    task automatic modelStep();
        logic [12:0] v;
        exp_t e;
        bit awHs, wHs, bHs, arHs, rHs, fin;
        int wrPre, rdPre, head;
        v = '0;
        e = '0;
        if (st.rst) begin
            awQ.delete(); arQ.delete();
            wBeatM = 0; rBeatM = 0; doneM = 0; armedM = 0; statusM = '0; prevSt = '0;
            expQ.push_back(e);
            return;
        end
        awHs = st.awv && st.awr; wHs = st.wv && st.wr; bHs = st.bv && st.br;
        arHs = st.arv && st.arr; rHs = st.rv && st.rr;
        if (prevSt.awv && !prevSt.awr && (!st.awv ||
            {st.awid, st.awaddr, st.awlen, st.awsize, st.awburst} !=
            {prevSt.awid, prevSt.awaddr, prevSt.awlen, prevSt.awsize, prevSt.awburst})) v[0] = 1'b1;
        if (prevSt.wv && !prevSt.wr && (!st.wv ||
            {st.wdata, st.wstrb, st.wlast} != {prevSt.wdata, prevSt.wstrb, prevSt.wlast})) v[1] = 1'b1;
        if (prevSt.arv && !prevSt.arr && (!st.arv ||
            {st.arid, st.araddr, st.arlen, st.arsize, st.arburst} !=
            {prevSt.arid, prevSt.araddr, prevSt.arlen, prevSt.arsize, prevSt.arburst})) v[2] = 1'b1;
        if (st.awv && int'(st.awlen) + 1 > MAXB) v[3] = 1'b1;
        if (st.arv && int'(st.arlen) + 1 > MAXB) v[4] = 1'b1;
        if (st.awv && st.awburst == 2'b01 &&
            int'(st.awaddr[11:0]) + (int'(st.awlen) + 1) * (1 << st.awsize) > 4096) v[12] = 1'b1;
        if (st.arv && st.arburst == 2'b01 &&
            int'(st.araddr[11:0]) + (int'(st.arlen) + 1) * (1 << st.arsize) > 4096) v[12] = 1'b1;

        wrPre = awQ.size() + doneM;
        rdPre = arQ.size();
        if (awHs) begin
            if (wrPre == MAXO) v[11] = 1'b1; else awQ.push_back(int'(st.awlen));
        end
        if (arHs) begin
            if (rdPre == MAXO) v[11] = 1'b1; else arQ.push_back(int'(st.arlen));
        end
        if (bHs) begin
            if (doneM == 0) v[8] = 1'b1; else doneM--;
        end
        if (wHs) begin
            if (awQ.size() == 0) begin
                if (!awHs) v[7] = 1'b1;
            end else begin
                head = awQ[0];
                if (st.wlast && wBeatM < head) v[5] = 1'b1;
                if (!st.wlast && wBeatM == head) v[6] = 1'b1;
                if (wBeatM == head) begin
                    void'(awQ.pop_front()); wBeatM = 0; doneM++;
                end else wBeatM++;
            end
        end
        if (rHs) begin
            if (arQ.size() == 0) begin
                if (!arHs) v[9] = 1'b1;
            end else begin
                fin = (rBeatM == arQ[0]);
                if (st.rlast != fin) v[10] = 1'b1;
                if (st.rlast || fin) begin
                    void'(arQ.pop_front()); rBeatM = 0;
                end else rBeatM++;
            end
        end
        if (!armedM) v = '0;
        armedM = 1'b1;
        prevSt = st;

        e.ev = st.en && (|v);
        for (int i = 12; i >= 0; i--) if (v[i]) e.ec = 4'(i);
        if (st.clr) statusM = '0;
        else if (st.en) statusM = statusM | v;
        e.es = statusM;
        e.wo = 4'(awQ.size() + doneM);
        e.ro = 4'(arQ.size());
        expQ.push_back(e);
    endtask

    task automatic applyStimulus();
        @(negedge clock);
        driveBus();
        modelStep();
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (err_valid !== e.ev) begin
            failures++;
            $display("[TB] FAIL err_valid got=%0b exp=%0b t=%0t", err_valid, e.ev, $time);
        end
        if (e.ev) begin
            checks++;
            if (err_code !== e.ec) begin
                failures++;
                $display("[TB] FAIL err_code got=%0d exp=%0d t=%0t", err_code, e.ec, $time);
            end
        end
        checks++;
        if (err_status !== e.es) begin
            failures++;
            $display("[TB] FAIL err_status got=%h exp=%h t=%0t", err_status, e.es, $time);
        end
        checks++;
        if (wr_outstanding !== e.wo) begin
            failures++;
            $display("[TB] FAIL wr_outstanding got=%0d exp=%0d t=%0t", wr_outstanding, e.wo, $time);
        end
        checks++;
        if (rd_outstanding !== e.ro) begin
            failures++;
            $display("[TB] FAIL rd_outstanding got=%0d exp=%0d t=%0t", rd_outstanding, e.ro, $time);
        end
    endtask

    task automatic idle();
        st = '0; st.en = 1'b1; st.wstrb = 4'hF;
    endtask
    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin idle(); applyStimulus(); end
    endtask
    task automatic resetCycle();
        idle(); st.rst = 1'b1; applyStimulus();
    endtask
    task automatic awIssue(input logic [31:0] a, input logic [7:0] len);
        idle(); st.awv = 1'b1; st.awr = 1'b1; st.awaddr = a; st.awlen = len;
        st.awsize = 3'd2; st.awburst = 2'b01; applyStimulus();
    endtask
    task automatic wSend(input logic last);
        idle(); st.wv = 1'b1; st.wr = 1'b1; st.wdata = $urandom; st.wlast = last; applyStimulus();
    endtask
    task automatic bSend();
        idle(); st.bv = 1'b1; st.br = 1'b1; applyStimulus();
    endtask
    task automatic arIssue(input logic [31:0] a, input logic [7:0] len);
        idle(); st.arv = 1'b1; st.arr = 1'b1; st.araddr = a; st.arlen = len;
        st.arsize = 3'd2; st.arburst = 2'b01; applyStimulus();
    endtask
    task automatic rSend(input logic last);
        idle(); st.rv = 1'b1; st.rr = 1'b1; st.rlast = last; applyStimulus();
    endtask

    // Mostly-legal traffic: payloads are held while stalled, LAST follows the model's beat
    // count, and each rule is broken now and then.
    task automatic randomCycle();
        st.rst = ($urandom_range(0, 499) == 0);
        st.en  = ($urandom_range(0, 19) != 0);
        st.clr = ($urandom_range(0, 39) == 0);
        if (!(st.awv && !st.awr && $urandom_range(0, 24) != 0)) begin
            st.awv = ($urandom_range(0, 2) == 0);
            st.awid = 4'($urandom);
            st.awaddr = $urandom;
            if ($urandom_range(0, 3) == 0) st.awaddr[11:0] = 12'($urandom_range(12'hF80, 12'hFFF));
            st.awlen = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(14, 40)) : 8'($urandom_range(0, 3));
            st.awsize = 3'($urandom_range(0, 2));
            st.awburst = 2'($urandom_range(0, 2));
        end
        st.awr = 1'($urandom_range(0, 1));
        if (!(st.wv && !st.wr && $urandom_range(0, 24) != 0)) begin
            st.wv = (awQ.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 30) == 0);
            st.wdata = $urandom;
            st.wstrb = 4'($urandom);
            st.wlast = (awQ.size() > 0) ? (wBeatM == awQ[0]) : 1'b1;
            if ($urandom_range(0, 29) == 0) st.wlast = !st.wlast;
        end
        st.wr = 1'($urandom_range(0, 1));
        st.bv = (doneM > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 40) == 0);
        st.br = 1'($urandom_range(0, 1));
        if (!(st.arv && !st.arr && $urandom_range(0, 24) != 0)) begin
            st.arv = ($urandom_range(0, 2) == 0);
            st.arid = 4'($urandom);
            st.araddr = $urandom;
            if ($urandom_range(0, 3) == 0) st.araddr[11:0] = 12'($urandom_range(12'hF80, 12'hFFF));
            st.arlen = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(14, 40)) : 8'($urandom_range(0, 3));
            st.arsize = 3'($urandom_range(0, 2));
            st.arburst = 2'($urandom_range(0, 2));
        end
        st.arr = 1'($urandom_range(0, 1));
        st.rv = (arQ.size() > 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 40) == 0);
        st.rlast = (arQ.size() > 0) ? (rBeatM == arQ[0]) : 1'b1;
        if ($urandom_range(0, 29) == 0) st.rlast = !st.rlast;
        st.rr = 1'($urandom_range(0, 1));
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired t=%0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        idle(); st.rst = 1'b1; driveBus();
        resetCycle(); resetCycle();

        // Legal write burst of four beats, response two cycles after the last beat.
        awIssue(32'h0000_1000, 8'd3);
        wSend(1'b0); wSend(1'b0); wSend(1'b0); wSend(1'b1);
        cycles(1); bSend(); cycles(2);

        // WLAST on beat 1 of a four-beat burst.
        awIssue(32'h0000_2000, 8'd3);
        wSend(1'b0); wSend(1'b1); wSend(1'b0); wSend(1'b1);
        cycles(1); bSend(); cycles(2);

        // AW address changes while stalled, then the sticky status is cleared.
        idle(); st.awv = 1'b1; st.awaddr = 32'h100; st.awburst = 2'b01; applyStimulus();
        idle(); st.awv = 1'b1; st.awaddr = 32'h104; st.awburst = 2'b01; applyStimulus();
        idle(); st.awv = 1'b1; st.awr = 1'b1; st.awaddr = 32'h104; st.awburst = 2'b01; applyStimulus();
        wSend(1'b1); cycles(1); bSend();
        idle(); st.clr = 1'b1; applyStimulus();
        cycles(2);

        // Nine reads with no data: the ninth overflows, then drain the eight accepted.
        for (int i = 0; i < 9; i++) arIssue(32'h3000 + 32'(i * 16), 8'd0);
        for (int i = 0; i < 8; i++) rSend(1'b1);
        cycles(2);

        // 4 KB boundary: 0xFF0 + 32 bytes crosses, 0xFE0 + 32 bytes ends exactly on it.
        arIssue(32'h0000_0FF0, 8'd7);
        arIssue(32'h0000_0FE0, 8'd7);
        for (int i = 0; i < 8; i++) rSend(i == 7);
        for (int i = 0; i < 8; i++) rSend(i == 7);
        cycles(2);

        // Reset in the middle of a write burst, then a fresh legal burst.
        awIssue(32'h0000_4000, 8'd3);
        wSend(1'b0); wSend(1'b0);
        resetCycle();
        cycles(1);
        awIssue(32'h0000_5000, 8'd1);
        wSend(1'b0); wSend(1'b1);
        cycles(1); bSend(); cycles(2);

        idle();
        for (int c = 0; c < 3000; c++) begin
            randomCycle();
            applyStimulus();
        end
        resetCycle();
        cycles(2);

        repeat (3) @(posedge clock);
        #2;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain got=%0d exp=0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi4_protocol_monitor.md
Name: axi4_protocol_monitor

Overview:
Passive, parametrised AXI4 protocol checker. It observes all five channels of an axi4_if instance and tracks outstanding write and read bursts. It checks handshake stability, burst length, 4 KB crossing, beat counts and response ordering. It reports violations as a one-cycle pulse plus a sticky status vector. It drives nothing onto the bus and sits alongside the interface in every testbench top and in debug builds of the SoC.

Parameters:
ID_WIDTH, 4, width of AWID/ARID/BID/RID
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width; WSTRB width is DATA_WIDTH/8
MAX_OUTSTANDING, 8, burst-tracking FIFO depth per direction (power of 2, >=2)
MAX_BURST_LEN, 16, maximum legal beats per burst (1..256)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = report violations; tracking runs regardless
clear_status  in  1  clears err_status next cycle
AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY, RLAST  in  1 each  observed handshake signals
AWID/ARID  in  ID_WIDTH  observed IDs (stability check only)
AWADDR/ARADDR  in  ADDR_WIDTH  observed addresses
AWLEN/ARLEN  in  8  observed burst lengths
AWSIZE/ARSIZE  in  3  observed burst sizes
AWBURST/ARBURST  in  2  observed burst types
WDATA  in  DATA_WIDTH  observed write data
WSTRB  in  DATA_WIDTH/8  observed write strobes
err_valid  out  1  one-cycle pulse when any violation is detected
err_code  out  4  index of the lowest-numbered violation in that cycle
err_status  out  13  sticky OR of all violations
wr_outstanding  out  $clog2(MAX_OUTSTANDING)+1  AW handshakes minus B handshakes
rd_outstanding  out  $clog2(MAX_OUTSTANDING)+1  AR handshakes minus final R beats

Behaviour:
- Handshake: a channel handshakes in a cycle where VALID && READY are sampled at posedge clock.
- Synchronous reset:
  - All outputs are 0.
  - All FIFOs and counters are empty/zero.
  - No checks fire in a reset cycle or in the first cycle after reset.
- Violation bits (bit index = err_code):
  - 0 AW_STABLE: in the previous cycle AWVALID=1 and AWREADY=0, and this cycle AWVALID dropped or any AW payload changed.
  - 1 W_STABLE: same rule for WVALID, WDATA, WSTRB, WLAST.
  - 2 AR_STABLE: same rule for the AR channel.
  - 3 AWLEN_RANGE: AWVALID and AWLEN+1 > MAX_BURST_LEN (9-bit compare).
  - 4 ARLEN_RANGE: same rule for ARLEN.
  - 5 WLAST_EARLY: WLAST on a W handshake whose beat count < head AWLEN.
  - 6 WLAST_MISSING: no WLAST on the beat where beat count == head AWLEN.
  - 7 W_NO_AW: W handshake with the AW FIFO empty and no AW handshake in the same cycle.
  - 8 B_UNEXPECTED: B handshake with completed-burst counter == 0.
  - 9 R_UNEXPECTED: R handshake with AR FIFO empty and no AR handshake in the same cycle.
  - 10 RLAST_ERR: RLAST asserted with beat count != head ARLEN, or RLAST absent with beat count == head ARLEN.
  - 11 OUTST_OVF: AW or AR handshake while the respective count == MAX_OUTSTANDING.
  - 12 BURST_4K: AWVALID or ARVALID with BURST==INCR and ADDR[11:0] + ((LEN+1) << SIZE) > 4096; compute at 21-bit width.
- Write tracking:
  - On an AW handshake, push AWLEN into the AW FIFO.
  - An AW and a W handshake in the same cycle: the W beat uses the new entry (bypass).
  - W beat counter increments per W handshake. On the head burst's final beat, pop the FIFO, zero the counter and increment the completed-burst counter.
  - On a B handshake, decrement the completed-burst counter (saturate at 0).
  - A B handshake in the same cycle as the completing WLAST is a violation (bit 8). B must follow at least one cycle later.
- Read tracking:
  - On an AR handshake, push ARLEN. Same-cycle AR and R handshakes use the bypass.
  - The R beat counter is checked against the FIFO head. Reads are in order; interleaving is outside the team subset.
  - On RLAST or on the expected final beat, pop the FIFO and zero the counter.
- Overflow: the handshake is flagged (bit 11), not pushed, and the count holds at MAX_OUTSTANDING.
- Outstanding counts: simultaneous push and pop leaves the count unchanged.
- Reporting:
  - Violation vector v computed each cycle.
  - err_valid = enable && |v, registered (1-cycle latency).
  - err_code = lowest set index of v.
  - err_status |= v when enable.
  - clear_status has priority over new violations in the same cycle.
- Reset mid-burst: all tracking state is discarded and no error is raised for abandoned bursts.

Test Plan:
- AW len=3, four W beats with WLAST on beat 3, B two cycles later -> no errors; wr_outstanding goes 1,1,...,0.
- WLAST on beat 1 of a len=3 burst -> err_valid pulse one cycle later, err_code=5, err_status[5]=1.
- AWVALID held with AWREADY=0 and AWADDR changed 0x100->0x104 -> err_code=0; then clear_status -> err_status=0.
- Nine AR handshakes, no R (MAX_OUTSTANDING=8) -> ninth flags err_code=11; rd_outstanding stays 8.
- AR INCR ARADDR=0xFF0 ARSIZE=2 ARLEN=7 (32 B) -> err_code=12; ARADDR=0xFE0 -> no error.
- Reset asserted mid write burst, then a fresh legal burst -> no errors; counters restart at 0.
